// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: session sequencer for the rhythm game.
// Runs the start countdown, paces scrolling with a programmable tick,
// prefetches one 4-lane chart row per tick over a req/ack handshake,
// handles pause/abort, drains the field at song end and keeps the best score.
module game_flow_ctrl #(
  parameter int TICK_DIV        = 2_500_000,
  parameter int CD_DIV          = 50_000_000,
  parameter int COUNTDOWN_STEPS = 3,
  parameter int DRAIN_ROWS      = 8,
  parameter int ADDR_W          = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_btn_i,
  input  logic              pause_btn_i,
  input  logic [31:0]       score_i,
  output logic              chart_req_o,
  output logic [ADDR_W-1:0] chart_addr_o,
  input  logic              chart_ack_i,
  input  logic [3:0]        chart_data_i,
  input  logic              chart_end_i,
  output logic              game_active_o,
  output logic              scroll_tick_o,
  output logic [3:0]        new_row_o,
  output logic [1:0]        countdown_o,
  output logic [2:0]        state_o,
  output logic [31:0]       best_score_o,
  output logic [7:0]        underrun_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_RUN       = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(CD_DIV);
  localparam int DW = $clog2(DRAIN_ROWS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CD_LAST    = CW'(CD_DIV - 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_ROWS);
  localparam logic [1:0]    CD_INIT    = 2'(COUNTDOWN_STEPS);

  state_e            state_q, state_d, ret_q, ret_d;
  logic              start_prev_q, pause_prev_q;
  logic [CW-1:0]     cd_tmr_q, cd_tmr_d;
  logic [1:0]        countdown_q, countdown_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        row_buf_q, row_buf_d;
  logic              row_valid_q, row_valid_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [31:0]       best_q, best_d;
  logic [7:0]        underrun_q, underrun_d;
  logic              scroll_q, scroll_d;
  logic [3:0]        new_row_q, new_row_d;
  logic              active_q, active_d;
  logic              enter_cd;

  logic start_rise_s, pause_rise_s, tick_wrap_s, fetch_ack_s, fetch_end_s;

  assign start_rise_s = start_btn_i & ~start_prev_q;
  assign pause_rise_s = pause_btn_i & ~pause_prev_q;
  assign tick_wrap_s  = (tick_q == TICK_LAST);
  // Late acks after an abort are harmless: req_q is already low then.
  assign fetch_ack_s  = req_q & chart_ack_i;
  assign fetch_end_s  = fetch_ack_s & chart_end_i;

  // Next-state, handshake, tick pacing and output computation.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cd_tmr_d    = cd_tmr_q;
    countdown_d = countdown_q;
    tick_d      = tick_q;
    req_d       = req_q;
    addr_d      = addr_q;
    row_buf_d   = row_buf_q;
    row_valid_d = row_valid_q;
    drain_d     = drain_q;
    best_d      = best_q;
    underrun_d  = underrun_q;
    scroll_d    = 1'b0;
    new_row_d   = 4'h0;
    enter_cd    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_rise_s) begin
          enter_cd = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_COUNTDOWN: begin
        if (start_rise_s) begin
          state_d     = ST_IDLE;
          countdown_d = 2'd0;
        end else if (cd_tmr_q == CD_LAST) begin
          cd_tmr_d    = {CW{1'b0}};
          countdown_d = countdown_q - 2'd1;
          if (countdown_q == 2'd1) begin
            // Fetch starts in the very first RUN cycle.
            state_d = ST_RUN;
            req_d   = 1'b1;
          end else begin
            state_d = ST_COUNTDOWN;
          end
        end else begin
          cd_tmr_d = cd_tmr_q + CW'(1);
        end
      end

      ST_RUN: begin
        if (start_rise_s) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end else begin
          if (fetch_ack_s) begin
            req_d = 1'b0;
            if (chart_end_i) begin
              drain_d = DRAIN_INIT;
            end else begin
              row_buf_d   = chart_data_i;
              row_valid_d = 1'b1;
            end
          end else begin
            req_d = req_q;
          end
          if (pause_rise_s) begin
            state_d = ST_PAUSE;
            ret_d   = fetch_end_s ? ST_DRAIN : ST_RUN;
          end else begin
            state_d = fetch_end_s ? ST_DRAIN : ST_RUN;
            tick_d  = tick_wrap_s ? {TW{1'b0}} : tick_q + TW'(1);
            if (tick_wrap_s) begin
              scroll_d = 1'b1;
              // Uses the pre-ack buffer: a row acked on this edge is the next row.
              if (row_valid_q) begin
                new_row_d   = row_buf_q;
                row_valid_d = 1'b0;
                addr_d      = addr_q + ADDR_W'(1);
              end else if (underrun_q != 8'hFF) begin
                underrun_d = underrun_q + 8'd1;
              end else begin
                underrun_d = underrun_q;
              end
            end else begin
              scroll_d = 1'b0;
            end
            // Request the next row as soon as the buffer empties.
            if (!row_valid_d && !req_d && !fetch_end_s) begin
              req_d = 1'b1;
            end else begin
              req_d = req_d;
            end
          end
        end
      end

      ST_PAUSE: begin
        if (start_rise_s) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end else begin
          // An outstanding request is still completed while paused.
          if (fetch_ack_s) begin
            req_d = 1'b0;
            if (chart_end_i) begin
              drain_d = DRAIN_INIT;
              ret_d   = ST_DRAIN;
            end else begin
              row_buf_d   = chart_data_i;
              row_valid_d = 1'b1;
            end
          end else begin
            req_d = req_q;
          end
          if (pause_rise_s) begin
            state_d = ret_d;
          end else begin
            state_d = ST_PAUSE;
          end
        end
      end

      ST_DRAIN: begin
        if (start_rise_s) begin
          state_d = ST_IDLE;
        end else if (pause_rise_s) begin
          state_d = ST_PAUSE;
          ret_d   = ST_DRAIN;
        end else begin
          tick_d = tick_wrap_s ? {TW{1'b0}} : tick_q + TW'(1);
          if (tick_wrap_s) begin
            scroll_d = 1'b1;
            drain_d  = drain_q - DW'(1);
            if (drain_q == DW'(1)) begin
              state_d = ST_DONE;
              best_d  = (score_i > best_q) ? score_i : best_q;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            scroll_d = 1'b0;
          end
        end
      end

      ST_DONE: begin
        if (start_rise_s) begin
          enter_cd = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (enter_cd) begin
      state_d     = ST_COUNTDOWN;
      countdown_d = CD_INIT;
      cd_tmr_d    = {CW{1'b0}};
      addr_d      = {ADDR_W{1'b0}};
      row_valid_d = 1'b0;
      tick_d      = {TW{1'b0}};
      underrun_d  = 8'd0;
      req_d       = 1'b0;
    end else begin
      enter_cd = 1'b0;
    end

    active_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_RUN;
      // Loading the live level means a button held through reset is no rise.
      start_prev_q <= start_btn_i;
      pause_prev_q <= pause_btn_i;
      cd_tmr_q     <= {CW{1'b0}};
      countdown_q  <= 2'd0;
      tick_q       <= {TW{1'b0}};
      req_q        <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      row_buf_q    <= 4'h0;
      row_valid_q  <= 1'b0;
      drain_q      <= {DW{1'b0}};
      best_q       <= 32'd0;
      underrun_q   <= 8'd0;
      scroll_q     <= 1'b0;
      new_row_q    <= 4'h0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      start_prev_q <= start_btn_i;
      pause_prev_q <= pause_btn_i;
      cd_tmr_q     <= cd_tmr_d;
      countdown_q  <= countdown_d;
      tick_q       <= tick_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      row_buf_q    <= row_buf_d;
      row_valid_q  <= row_valid_d;
      drain_q      <= drain_d;
      best_q       <= best_d;
      underrun_q   <= underrun_d;
      scroll_q     <= scroll_d;
      new_row_q    <= new_row_d;
      active_q     <= active_d;
    end
  end

  assign chart_req_o    = req_q;
  assign chart_addr_o   = addr_q;
  assign game_active_o  = active_q;
  assign scroll_tick_o  = scroll_q;
  assign new_row_o      = new_row_q;
  assign countdown_o    = countdown_q;
  assign state_o        = state_q;
  assign best_score_o   = best_q;
  assign underrun_cnt_o = underrun_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: stimulus pushes expected tick rows,
// a monitor pops them on every scroll_tick; state checks are directed.
module tb_game_flow_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_btn;
  logic        pause_btn;
  logic [31:0] score;
  logic        chart_req;
  logic [7:0]  chart_addr;
  logic        chart_ack;
  logic [3:0]  chart_data;
  logic        chart_end;
  logic        game_active;
  logic        scroll_tick;
  logic [3:0]  new_row;
  logic [1:0]  countdown;
  logic [2:0]  state;
  logic [31:0] best_score;
  logic [7:0]  underrun_cnt;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  int rom_lat = 1;
  int rom_age = 0;
  logic [3:0] rom_data [0:3] = '{4'h1, 4'h8, 4'h0, 4'h0};
  logic       rom_end  [0:3] = '{1'b0, 1'b0, 1'b1, 1'b1};

  game_flow_ctrl #(
    .TICK_DIV(4), .CD_DIV(3), .COUNTDOWN_STEPS(2), .DRAIN_ROWS(2), .ADDR_W(8)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_btn_i(start_btn), .pause_btn_i(pause_btn),
    .score_i(score), .chart_req_o(chart_req), .chart_addr_o(chart_addr),
    .chart_ack_i(chart_ack), .chart_data_i(chart_data), .chart_end_i(chart_end),
    .game_active_o(game_active), .scroll_tick_o(scroll_tick), .new_row_o(new_row),
    .countdown_o(countdown), .state_o(state), .best_score_o(best_score),
    .underrun_cnt_o(underrun_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL %s: state %0d expected %0d after %0d cycles", name, state, s, n);
    end
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic press_pause();
    pause_btn = 1'b1;
    @(negedge clk);
    pause_btn = 1'b0;
  endtask

  // Chart ROM: acks once req has been seen for rom_lat cycles, one-cycle ack.
  initial begin
    chart_ack  = 1'b0;
    chart_data = 4'h0;
    chart_end  = 1'b0;
    forever begin
      @(negedge clk);
      if (chart_req && !chart_ack) begin
        if (rom_age >= rom_lat) begin
          chart_ack  = 1'b1;
          chart_data = rom_data[chart_addr[1:0]];
          chart_end  = rom_end[chart_addr[1:0]];
          rom_lat    = 1;
          rom_age    = 0;
        end else begin
          rom_age++;
        end
      end else begin
        chart_ack  = 1'b0;
        chart_data = 4'h0;
        chart_end  = 1'b0;
        rom_age    = 0;
      end
    end
  end

  // Monitor: every tick pops one expected row; no row may appear without a tick.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && scroll_tick) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tick_unexpected: row %0h with empty scoreboard", new_row);
        end else begin
          e = exp_q.pop_front();
          if (new_row !== e) begin
            errors++;
            $display("FAIL tick_row: got %0h expected %0h", new_row, e);
          end
        end
      end else if (rst_n && new_row !== 4'h0) begin
        checks++;
        errors++;
        $display("FAIL row_idle: got %0h expected 0 without tick", new_row);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    start_btn = 1'b1;
    pause_btn = 1'b0;
    score     = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state with start held
    check("rst_state", state, 0);
    check("rst_req", chart_req, 0);
    check("rst_addr", chart_addr, 0);
    check("rst_active", game_active, 0);
    check("rst_tick", scroll_tick, 0);
    check("rst_countdown", countdown, 0);
    check("rst_best", best_score, 0);
    check("rst_underrun", underrun_cnt, 0);
    repeat (3) @(negedge clk);
    check("held_btn_no_start", state, 0);
    start_btn = 1'b0;
    @(negedge clk);

    // Session 1: countdown, rows 1, 8, end
    score = 32'd350;
    exp_q.push_back(4'h1); exp_q.push_back(4'h8);
    exp_q.push_back(4'h0); exp_q.push_back(4'h0);
    press_start();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      check("cd_value", countdown, (i < 3) ? 2 : 1);
    end
    @(negedge clk);
    check("run_state", state, 2);
    check("run_active", game_active, 1);
    check("run_req", chart_req, 1);
    check("run_addr", chart_addr, 0);
    check("run_countdown", countdown, 0);
    wait_state(3'd5, 40, "done1");
    @(negedge clk);
    check("done1_best", best_score, 350);
    check("done1_active", game_active, 0);
    check("done1_underrun", underrun_cnt, 0);
    check("done1_queue", exp_q.size(), 0);

    // Session 2: first fetch stalled 10 cycles, lower final score
    score   = 32'd200;
    rom_lat = 10;
    exp_q.push_back(4'h0); exp_q.push_back(4'h0); exp_q.push_back(4'h1);
    exp_q.push_back(4'h8); exp_q.push_back(4'h0); exp_q.push_back(4'h0);
    press_start();
    wait_state(3'd2, 20, "run2");
    repeat (10) @(negedge clk);
    check("stall_addr", chart_addr, 0);
    check("stall_underrun", underrun_cnt, 2);
    wait_state(3'd5, 40, "done2");
    @(negedge clk);
    check("done2_best", best_score, 350);
    check("done2_underrun", underrun_cnt, 2);
    check("done2_queue", exp_q.size(), 0);

    // Session 3: pause with a request outstanding
    score   = 32'd500;
    rom_lat = 5;
    exp_q.push_back(4'h1); exp_q.push_back(4'h8);
    exp_q.push_back(4'h0); exp_q.push_back(4'h0);
    press_start();
    wait_state(3'd2, 20, "run3");
    @(negedge clk);
    press_pause();
    check("pause_state", state, 3);
    check("pause_active", game_active, 0);
    check("pause_req_held", chart_req, 1);
    for (int i = 0; i < 6; i++) begin
      check("pause_no_tick", scroll_tick, 0);
      check("pause_hold", state, 3);
      @(negedge clk);
    end
    check("pause_ack_taken", chart_req, 0);
    press_pause();
    check("resume_state", state, 2);
    for (int i = 0; i < 3; i++) begin
      check("resume_wait", scroll_tick, 0);
      @(negedge clk);
    end
    check("resume_tick", scroll_tick, 1);
    wait_state(3'd5, 40, "done3");
    @(negedge clk);
    check("done3_best", best_score, 500);
    check("done3_queue", exp_q.size(), 0);

    // Session 4: start and pause together during RUN
    score   = 32'd900;
    rom_lat = 3;
    press_start();
    wait_state(3'd2, 20, "run4");
    check("abort_req_before", chart_req, 1);
    start_btn = 1'b1;
    pause_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    pause_btn = 1'b0;
    check("abort_state", state, 0);
    check("abort_req", chart_req, 0);
    check("abort_active", game_active, 0);
    check("abort_best", best_score, 500);
    repeat (4) @(negedge clk);
    check("abort_idle_hold", state, 0);
    check("abort_req_hold", chart_req, 0);
    check("final_queue", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
